// File: rtl/fpu_issuer.sv
// fpu_issuer: queues host add/sub requests and issues them one at a time to a
// single fpu_add; a watchdog turns a hung FPU into a flagged qNaN response.
module fpu_issuer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] fpu_din1,
   output logic [31:0] fpu_din2,
   output logic        fpu_valid,
   input  logic [31:0] fpu_result,
   input  logic        fpu_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout
);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
   localparam logic [31:0]    QNAN     = 32'h7FC0_0000;

   typedef struct packed {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t         state, state_nxt;
   req_t           mem [DEPTH];
   req_t           head;
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic [WDW-1:0] wdog;
   logic           push, pop, wd_expire;

   assign req_ready = (count != CNT_FULL);
   assign push      = req_valid && req_ready;
   assign pop       = (state == S_IDLE) && (count != '0);
   assign head      = mem[rd_ptr];
   assign wd_expire = (wdog == WD_LAST);
   assign fpu_valid = (state == S_ISSUE);
   assign rsp_valid = (state == S_RESP);

   // Storage carries no reset: occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {req_op, req_a, req_b};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (pop) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (fpu_ready || wd_expire) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A real result beats the watchdog when both land on the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpu_din1    <= '0;
         fpu_din2    <= '0;
         wdog        <= '0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         if (pop) begin
            fpu_din1 <= head.a;
            fpu_din2 <= head.op ? {~head.b[31], head.b[30:0]} : head.b;
         end
         if (state == S_ISSUE)     wdog <= '0;
         else if (state == S_WAIT) wdog <= wdog + WDW'(1);
         if (state == S_WAIT) begin
            if (fpu_ready) begin
               rsp_data    <= fpu_result;
               rsp_timeout <= 1'b0;
            end else if (wd_expire) begin
               rsp_data    <= QNAN;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_issuer.sv
// Scoreboard bench for fpu_issuer: a behavioural FPU checks issued operands,
// a monitor pops expected responses on each host handshake.
module tb_fpu_issuer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk, reset;
   logic        req_valid, req_ready, req_op;
   logic [31:0] req_a, req_b;
   logic [31:0] fpu_din1, fpu_din2, fpu_result;
   logic        fpu_valid, fpu_ready;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_data;

   typedef struct { logic [31:0] d1, d2, res; } iss_t;
   typedef struct { logic [31:0] data; logic to; } rsp_t;

   iss_t iss_q[$];
   rsp_t exp_q[$];
   int   total = 0, bad = 0;
   int   model_lat = 3;
   int   poke_req = 0;
   logic [31:0] poke_val = '0;

   fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_valid(fpu_valid),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not end, bad=%0d", bad);
      $fatal(1, "stuck");
   end

   // Behavioural FPU: latency model_lat negedges after the issue, 0 = hang.
   initial begin
      int   cd;
      int   poke_seen;
      logic prev_v;
      logic [31:0] pend;
      iss_t ie;
      fpu_ready = 1'b0; fpu_result = '0; cd = 0; prev_v = 1'b0; poke_seen = 0; pend = '0;
      forever begin
         @(negedge clk);
         fpu_ready = 1'b0;
         if (fpu_valid) begin
            total++;
            if (prev_v) begin
               bad++;
               $display("FAIL fpu_valid_pulse: high 2 cycles, want 1");
            end else if (iss_q.size() == 0) begin
               bad++;
               $display("FAIL issue: unexpected issue din1=%h din2=%h", fpu_din1, fpu_din2);
            end else begin
               ie = iss_q.pop_front();
               if (fpu_din1 !== ie.d1 || fpu_din2 !== ie.d2) begin
                  bad++;
                  $display("FAIL issue_ops: got %h/%h want %h/%h", fpu_din1, fpu_din2, ie.d1, ie.d2);
               end
               cd = model_lat; pend = ie.res;
            end
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin fpu_ready = 1'b1; fpu_result = pend; end
         end
         if (poke_req != poke_seen) begin
            poke_seen = poke_req; fpu_ready = 1'b1; fpu_result = poke_val;
         end
         if (!reset) cd = 0;
         prev_v = fpu_valid;
      end
   end

   // Response monitor.
   initial begin
      rsp_t er;
      forever begin
         @(negedge clk);
         if (reset && rsp_valid && rsp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rsp: unexpected response data=%h to=%b", rsp_data, rsp_timeout);
            end else begin
               er = exp_q.pop_front();
               if (rsp_data !== er.data || rsp_timeout !== er.to) begin
                  bad++;
                  $display("FAIL rsp: got %h/%b want %h/%b", rsp_data, rsp_timeout, er.data, er.to);
               end
            end
         end
      end
   end

   task automatic push_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d2, input logic [31:0] res,
                           input logic [31:0] rdata, input logic rto);
      iss_t ie;
      rsp_t er;
      int   n;
      ie.d1 = a; ie.d2 = d2; ie.res = res;
      er.data = rdata; er.to = rto;
      iss_q.push_back(ie);
      exp_q.push_back(er);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL push: req_ready stuck low");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0) && n < limit) begin
         @(negedge clk); n++;
      end
      total++;
      if (exp_q.size() != 0 || iss_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending rsp=%0d issue=%0d, want 0/0", exp_q.size(), iss_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({fpu_valid, fpu_din1, fpu_din2, rsp_valid, rsp_data, rsp_timeout} !== '0) begin
         bad++;
         $display("FAIL reset_outs: v=%b d1=%h d2=%h rv=%b rd=%h rt=%b, want all 0",
                  fpu_valid, fpu_din1, fpu_din2, rsp_valid, rsp_data, rsp_timeout);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || fpu_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: req_ready=%b rsp_valid=%b fpu_valid=%b want 1/0/0",
                  req_ready, rsp_valid, fpu_valid);
      end
   endtask

   task automatic test_add();
      model_lat = 3; rsp_ready = 1'b1;
      push_req(1'b0, 32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 32'h4070_0000, 32'h4070_0000, 1'b0);
      @(negedge clk);
      total++;
      if (fpu_valid !== 1'b0) begin bad++; $display("FAIL add_lat0: fpu_valid=%b want 0", fpu_valid); end
      @(negedge clk);
      total++;
      if (fpu_valid !== 1'b1) begin bad++; $display("FAIL add_lat1: fpu_valid=%b want 1", fpu_valid); end
      wait_drain(50);
   endtask

   task automatic test_sub();
      model_lat = 4; rsp_ready = 1'b1;
      push_req(1'b1, 32'h40A0_0000, 32'h4040_0000, 32'hC040_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
      // NaN operand: subtract still flips bit 31, no other change
      push_req(1'b1, 32'h7FC0_0001, 32'h7FC0_0000, 32'hFFC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
      push_req(1'b0, 32'hFF80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
      wait_drain(100);
   endtask

   task automatic test_timeout();
      int n;
      model_lat = 0; rsp_ready = 1'b0;
      push_req(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0, QNAN, 1'b1);
      n = 0;
      while (!fpu_valid && n < 10) begin @(negedge clk); n++; end
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 200) begin n++; @(negedge clk); end
      total++;
      if (n !== TIMEOUT) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT); end
      total++;
      if (rsp_data !== QNAN || rsp_timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_rsp: got %h/%b want %h/1", rsp_data, rsp_timeout, QNAN);
      end
      poke_val = 32'h3F80_0000; poke_req++;
      repeat (3) @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== QNAN || rsp_timeout !== 1'b1) begin
         bad++;
         $display("FAIL late_ready_resp: got v=%b %h/%b want 1 %h/1", rsp_valid, rsp_data, rsp_timeout, QNAN);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_drain(10);
      poke_val = 32'h1234_5678; poke_req++;
      repeat (5) @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || fpu_valid !== 1'b0) begin
         bad++;
         $display("FAIL late_ready_idle: rsp_valid=%b fpu_valid=%b want 0/0", rsp_valid, fpu_valid);
      end
      @(posedge clk); #1;
      model_lat = 3;
      push_req(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 1'b0);
      wait_drain(50);
   endtask

   task automatic test_coincident();
      model_lat = TIMEOUT; rsp_ready = 1'b1;
      push_req(1'b0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
      wait_drain(150);
   endtask

   task automatic test_back_to_back_full();
      iss_t ie;
      rsp_t er;
      int   k = 0;
      model_lat = 2; rsp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         req_a = 32'h4000_0000 | k; req_b = 32'h3000_0000 | k;
         @(negedge clk);
         if (req_ready) begin
            ie.d1 = req_a; ie.d2 = req_b; ie.res = 32'h4100_0000 + k;
            er.data = 32'h4100_0000 + k; er.to = 1'b0;
            iss_q.push_back(ie); exp_q.push_back(er);
            k++;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      total++;
      if (k !== DEPTH + 1 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_accept: accepted=%0d req_ready=%b want %0d/0", k, req_ready, DEPTH + 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL full_rel0: req_ready=%b want 0", req_ready); end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL full_rel1: req_ready=%b want 0", req_ready); end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL full_rel2: req_ready=%b want 1", req_ready); end
      wait_drain(200);
   endtask

   task automatic test_reset_mid();
      logic seen;
      model_lat = 0; rsp_ready = 1'b1;
      push_req(1'b0, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h0, QNAN, 1'b1);
      push_req(1'b1, 32'h4050_0000, 32'h4060_0000, 32'hC060_0000, 32'h0, 32'h0, 1'b0);
      push_req(1'b0, 32'h4070_0000, 32'h4080_0000, 32'h4080_0000, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      total++;
      if ({fpu_valid, fpu_din1, fpu_din2, rsp_valid, rsp_data, rsp_timeout} !== '0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid: v=%b d1=%h d2=%h rv=%b rd=%h rt=%b rr=%b, want zeros, rr=1",
                  fpu_valid, fpu_din1, fpu_din2, rsp_valid, rsp_data, rsp_timeout, req_ready);
      end
      iss_q.delete(); exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid || fpu_valid || !req_ready) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_quiet: activity seen=%b want 0", seen); end
      @(posedge clk); #1;
      model_lat = 3;
      push_req(1'b0, 32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 32'h4070_0000, 32'h4070_0000, 1'b0);
      wait_drain(50);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_timeout();
      test_coincident();
      test_back_to_back_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
